// File: rtl/arb_multi_mode_pkg.sv
// Shared types and helpers for the multi-mode arbiter.
// Arbitration mode encodings, lock-FSM states and matrix triangle indexing.
package arb_multi_mode_pkg;

    // Existing encodings kept; round-robin appended.
    typedef enum logic [1:0] {
        ARB_MATRIX         = 2'd0,
        ARB_FIXED_PRIORITY = 2'd1,
        ARB_ROUND_ROBIN    = 2'd2
    } arbiter_type_e;

    localparam logic [0:0] LOCK_IDLE = 1'b0;
    localparam logic [0:0] LOCK_HELD = 1'b1;

    // Flat position of W[i][j] (i<j) in the stored upper triangle of an n x n matrix.
    function automatic int unsigned tri_idx(
        input int unsigned i,
        input int unsigned j,
        input int unsigned n
    );
        return i * n - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/arb_find_first.sv
// First set bit of vec at or after start, wrapping; one-hot and binary index.
// Both outputs are zero when vec is empty.
module arb_find_first #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    input  logic [IDX_W-1:0] start,
    output logic [WIDTH-1:0] onehot,
    output logic [IDX_W-1:0] idx
);

    logic        found;
    int unsigned pos;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        pos    = 0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            pos = 32'(start) + k;
            if (pos >= WIDTH) begin
                pos = pos - WIDTH;
            end
            if (!found && vec[IDX_W'(pos)]) begin
                found                = 1'b1;
                onehot[IDX_W'(pos)]  = 1'b1;
                idx                  = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/arb_multi_mode.sv
// N-requestor arbiter: fixed-priority, round-robin or matrix (LRU) mode, with
// per-requestor grant lock and an advance handshake that moves fairness state.
module arb_multi_mode
    import arb_multi_mode_pkg::*;
#(
    parameter int unsigned   NUM_REQ  = 4,
    parameter arbiter_type_e ARB_TYPE = ARB_MATRIX,
    parameter int unsigned   IDX_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] lock,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid,
    output logic               locked
);

    localparam int unsigned TRI_W  = NUM_REQ * (NUM_REQ - 1) / 2;
    localparam int unsigned TRI_IW = (TRI_W > 1) ? $clog2(TRI_W) : 1;

    logic [NUM_REQ-1:0] free_grant;
    logic [IDX_W-1:0]   free_idx;
    logic [NUM_REQ-1:0] grant_int;
    logic [IDX_W-1:0]   idx_int;
    logic               beat;

    logic [0:0]         lock_state_q;
    logic [0:0]         lock_state_d;
    logic [IDX_W-1:0]   owner_q;
    logic [IDX_W-1:0]   owner_d;
    logic [NUM_REQ-1:0] owner_oh;
    logic               owner_req;
    logic               owner_lock;
    logic               win_lock;

    assign owner_oh   = NUM_REQ'(1) << owner_q;
    assign owner_req  = |(owner_oh & req);
    assign owner_lock = |(owner_oh & lock);
    assign win_lock   = |(grant_int & lock);
    assign beat       = advance & (|grant_int);

    // While locked only the owner can hold the grant, even if it drops req.
    always_comb begin
        grant_int = free_grant;
        idx_int   = free_idx;
        if (lock_state_q == LOCK_HELD) begin
            grant_int = owner_oh & req;
            idx_int   = owner_req ? owner_q : '0;
        end
    end

    // Outputs read as idle for the whole time reset is held.
    assign grant       = reset_n ? grant_int : '0;
    assign grant_idx   = reset_n ? idx_int : '0;
    assign grant_valid = |grant;
    assign locked      = (lock_state_q == LOCK_HELD);

    always_comb begin
        lock_state_d = lock_state_q;
        owner_d      = owner_q;
        case (lock_state_q)
            LOCK_IDLE: begin
                if (beat && win_lock) begin
                    lock_state_d = LOCK_HELD;
                    owner_d      = idx_int;
                end
            end
            LOCK_HELD: begin
                if ((advance && !owner_lock) || !owner_req) begin
                    lock_state_d = LOCK_IDLE;
                end
            end
            default: lock_state_d = LOCK_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_state_q <= LOCK_IDLE;
            owner_q      <= '0;
        end else begin
            lock_state_q <= lock_state_d;
            owner_q      <= owner_d;
        end
    end

    if (ARB_TYPE == ARB_ROUND_ROBIN) begin : g_rr
        logic [IDX_W-1:0] ptr_q;
        logic [IDX_W-1:0] ptr_d;

        always_comb begin
            ptr_d = ptr_q;
            if (beat) begin
                ptr_d = (idx_int == IDX_W'(NUM_REQ - 1)) ? '0 : idx_int + IDX_W'(1);
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= ptr_d;
            end
        end

        arb_find_first #(
            .WIDTH (NUM_REQ),
            .IDX_W (IDX_W)
        ) u_find (
            .vec    (req),
            .start  (ptr_q),
            .onehot (free_grant),
            .idx    (free_idx)
        );
    end else if (ARB_TYPE == ARB_FIXED_PRIORITY) begin : g_fixed
        arb_find_first #(
            .WIDTH (NUM_REQ),
            .IDX_W (IDX_W)
        ) u_find (
            .vec    (req),
            .start  (IDX_W'(0)),
            .onehot (free_grant),
            .idx    (free_idx)
        );
    end else begin : g_matrix
        // Upper triangle of W only; W[j][i] for j>i is the complement of W[i][j].
        logic [TRI_W-1:0] tri_q;
        logic [TRI_W-1:0] tri_d;
        logic             win;

        always_comb begin
            free_grant = '0;
            free_idx   = '0;
            win        = 1'b0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                win = req[i];
                for (int unsigned j = 0; j < NUM_REQ; j++) begin
                    if (j < i) begin
                        if (req[j] && tri_q[TRI_IW'(tri_idx(j, i, NUM_REQ))]) begin
                            win = 1'b0;
                        end
                    end else if (j > i) begin
                        if (req[j] && !tri_q[TRI_IW'(tri_idx(i, j, NUM_REQ))]) begin
                            win = 1'b0;
                        end
                    end
                end
                if (win) begin
                    free_grant[i] = 1'b1;
                    free_idx      = IDX_W'(i);
                end
            end
        end

        // Demote the winner: clear its row, set its column.
        always_comb begin
            tri_d = tri_q;
            if (beat) begin
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    for (int unsigned j = i + 1; j < NUM_REQ; j++) begin
                        if (IDX_W'(i) == idx_int) begin
                            tri_d[TRI_IW'(tri_idx(i, j, NUM_REQ))] = 1'b0;
                        end
                        if (IDX_W'(j) == idx_int) begin
                            tri_d[TRI_IW'(tri_idx(i, j, NUM_REQ))] = 1'b1;
                        end
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                tri_q <= '1;
            end else begin
                tri_q <= tri_d;
            end
        end
    end

endmodule

// File: doc/arb_multi_mode.md
# arb_multi_mode

Parametrised N-requestor arbiter, successor to the two-mode arbiter selected by `TopPkg::ArbiterType`. It adds a round-robin mode, a grant-lock for multi-cycle transfers, and an explicit `advance` handshake that decides when fairness state moves. It sits between requesting agents and a shared resource such as a bus port, memory bank or scan-chain access port, one instance per resource.

## Interface
- `NUM_REQ`, 4: number of requestors, legal range 2..32.
- `ARB_TYPE`, `ARB_MATRIX`: `TopPkg::ArbiterType`, one of `ARB_MATRIX`, `ARB_FIXED_PRIORITY` or `ARB_ROUND_ROBIN`.
- `IDX_W`, `$clog2(NUM_REQ)`: width of the index output. Derived; never overridden.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous assert, active-low.
- `req` in NUM_REQ: request vector, level-sensitive.
- `lock` in NUM_REQ: per-requestor hold-grant; sampled only for the granted index.
- `advance` in 1: consumer accepted the current grant this cycle.
- `grant` out NUM_REQ: one-hot grant, or all zero.
- `grant_idx` out IDX_W: binary index of the grant; 0 when `grant_valid`=0.
- `grant_valid` out 1: equals `|grant`.
- `locked` out 1: lock currently held.

## Operation
- Grant is combinational from `req` and the registered state (priority state, `locked_q`, `owner_q`). It is never more than one-hot.
- `ARB_FIXED_PRIORITY`: the lowest set index of `req` wins. No priority state.
- `ARB_ROUND_ROBIN`: pointer `ptr_q`. The search starts at `ptr_q`, ascending, and wraps modulo NUM_REQ. On `advance` with winner w, `ptr_q` <= (w+1) mod NUM_REQ. When w=NUM_REQ-1, the pointer wraps to 0.
- `ARB_MATRIX`: NUM_REQ×NUM_REQ priority matrix W, where W[i][j]=1 means i beats j. Only the upper triangle is stored; the lower triangle is its complement. Requestor i wins if req[i] and no j with req[j] has W[j][i]=1. On `advance` with winner w: row w is cleared and column w is set, so w becomes lowest priority.
- Lock:
  - `advance` && `grant_valid` && `lock[w]` sets `locked_q`=1 and `owner_q`=w.
  - While `locked_q`=1: `grant` = onehot(`owner_q`) & `req`. No other requestor is granted, even if the owner drops `req`.
  - Lock clears at the edge where (`advance` && !`lock[owner_q]`) or !`req[owner_q]`.
  - `locked` = `locked_q`.
- Priority state updates on every `advance` with `grant_valid`=1, including locked beats. Re-demoting the same winner is idempotent.
- `advance` with `grant_valid`=0 is ignored: no state change.

## Timing
- Request-to-grant latency is 0 cycles (combinational). A state change on `advance` affects the grant from the next cycle.
- Reset values:
  - `grant`=0, `grant_idx`=0, `grant_valid`=0, `locked`=0.
  - `ptr_q`=0.
  - W[i][j]=1 for all i<j, so index 0 has highest priority.
  - `locked_q`=0, `owner_q`=0.
- Reset asserted mid-lock: the lock drops immediately (asynchronously). After release, arbitration starts from the reset priority.
- Simultaneous lock-clear and new request: the lock clears at the edge. The next winner is chosen in the following cycle using the updated priority state.
- `req` may change any cycle. The consumer must assert `advance` only in a cycle where `grant_valid`=1.

## Structure
- `TopPkg` gains `ARB_ROUND_ROBIN` in `ArbiterType`; the enum widens to 2 bits. Existing encodings are unchanged.
- Only the state for the selected `ARB_TYPE` is generated; the others are not elaborated.
- Sub-module `arb_find_first`: combinational, parametrised width. It takes a vector plus a start index and returns a one-hot and a binary index of the first set bit at or after start, with wrap. It is shared by the fixed-priority mode (start=0) and round-robin mode.

## Test plan
All scenarios use NUM_REQ=4.
- Reset/idle, all modes: `req`=0 -> `grant`=0, `grant_valid`=0, `locked`=0. Reset release with `req`=4'b1111 -> `grant`=4'b0001.
- FIXED: `req`=4'b1010 with `advance` every cycle -> `grant`=4'b0010 on every cycle; no rotation.
- ROUND_ROBIN: `req`=4'b1111 and `advance` held for 5 cycles -> grants 0001, 0010, 0100, 1000, 0001 (wrap).
- MATRIX: `req`=4'b0111, advance 0 then 1 -> grants 0001, 0010. Then `req`=4'b0011 -> `grant`=4'b0001, because 0 now beats demoted 1.
- Lock: `req`=4'b0011, `lock`=4'b0010, ROUND_ROBIN with `ptr_q`=1 -> grant 0010 and `locked`=1 after advance. Grant stays 0010 for 3 advances. Drop `lock[1]` with advance -> next cycle `grant`=4'b0001.
- Reset mid-lock: pulse `reset_n` low while locked -> `locked`=0 and `grant`=0 immediately; after release, grant follows reset priority.
